// File: rtl/hamming74_receiver.sv
// Hamming(7,4) single-error-correcting receiver: capture -> decode -> output handshake FSM.
// Optional saturating corrected-error counter is built only when HAMMING_RX_ERR_COUNT_EN is defined.
module hamming74_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] rx,
    input  logic       rx_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [3:0] data_out,
    output logic       out_valid,
    output logic       err_corrected,
    output logic [2:0] err_pos,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t     r_state;
    logic [6:0] r_rxWord;
    logic       r_busy;
    logic       r_outValid;
    logic       r_errCorrected;
    logic [3:0] r_dataOut;
    logic [2:0] r_errPos;

    logic [2:0] w_syndrome;
    logic [6:0] w_flipMask;
    logic [6:0] w_corrected;
    logic [3:0] w_data;
    logic       w_handshake;

    // Bit k of the captured word is codeword position k+1.
    assign w_syndrome[0] = r_rxWord[0] ^ r_rxWord[2] ^ r_rxWord[4] ^ r_rxWord[6];
    assign w_syndrome[1] = r_rxWord[1] ^ r_rxWord[2] ^ r_rxWord[5] ^ r_rxWord[6];
    assign w_syndrome[2] = r_rxWord[3] ^ r_rxWord[4] ^ r_rxWord[5] ^ r_rxWord[6];

    always_comb begin
        w_flipMask = 7'b0000000;
        case (w_syndrome)
            3'd1:    w_flipMask = 7'b0000001;
            3'd2:    w_flipMask = 7'b0000010;
            3'd3:    w_flipMask = 7'b0000100;
            3'd4:    w_flipMask = 7'b0001000;
            3'd5:    w_flipMask = 7'b0010000;
            3'd6:    w_flipMask = 7'b0100000;
            3'd7:    w_flipMask = 7'b1000000;
            default: w_flipMask = 7'b0000000;
        endcase
    end

    assign w_corrected = r_rxWord ^ w_flipMask;
    assign w_data      = {w_corrected[6], w_corrected[5], w_corrected[4], w_corrected[2]};
    assign w_handshake = (r_state == OUTPUT) && out_ready;

    // Results stay registered after the handshake so data_out/err_pos keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rxWord       <= 7'd0;
            r_busy         <= 1'b0;
            r_outValid     <= 1'b0;
            r_errCorrected <= 1'b0;
            r_dataOut      <= 4'd0;
            r_errPos       <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_rxWord <= rx;
                        r_busy   <= 1'b1;
                        r_state  <= DECODE;
                    end
                end
                DECODE: begin
                    r_dataOut      <= w_data;
                    r_errPos       <= w_syndrome;
                    r_errCorrected <= (w_syndrome != 3'd0);
                    r_outValid     <= 1'b1;
                    r_state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign out_valid     = r_outValid;
    assign data_out      = r_dataOut;
    assign err_corrected = r_errCorrected;
    assign err_pos       = r_errPos;

`ifdef HAMMING_RX_ERR_COUNT_EN
    logic [7:0] r_errCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= 8'd0;
        end else if (w_handshake && r_errCorrected && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end

    assign err_count = r_errCount;
`else
    logic w_unusedHandshake;
    assign w_unusedHandshake = w_handshake;
    assign err_count         = 8'd0;
`endif

endmodule

// File: tb/tb_hamming74_receiver.sv
// Self-checking bench for hamming74_receiver: fixed vectors, random words against a
// position-XOR Hamming model, backpressure, back-to-back, mid-decode reset and error counter.
module tb_hamming74_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rx;
    logic       rx_valid;
    logic       out_ready;
    logic       busy;
    logic [3:0] data_out;
    logic       out_valid;
    logic       err_corrected;
    logic [2:0] err_pos;
    logic [7:0] err_count;

    int checks    = 0;
    int errors    = 0;
    int corrCount = 0;

    hamming74_receiver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_valid      (rx_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .err_corrected (err_corrected),
        .err_pos       (err_pos),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Syndrome is the XOR of the position numbers of every set bit.
    function automatic logic [2:0] modelSyndrome(input logic [6:0] w);
        int s = 0;
        for (int p = 1; p <= 7; p++)
            if (w[p-1]) s = s ^ p;
        return 3'(s);
    endfunction

    function automatic logic [3:0] modelData(input logic [6:0] w);
        logic [6:0] c;
        int s;
        c = w;
        s = int'(modelSyndrome(w));
        if (s != 0) c[s-1] = ~c[s-1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [6:0] modelEncode(input logic [3:0] d);
        logic [6:0] w;
        logic [2:0] s;
        w    = 7'd0;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        s    = modelSyndrome(w);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        return w;
    endfunction

    function automatic void modelHandshake(input logic [6:0] w);
        if (modelSyndrome(w) != 3'd0 && corrCount < 255) corrCount++;
    endfunction

    function automatic logic [7:0] expErrCount();
`ifdef HAMMING_RX_ERR_COUNT_EN
        return 8'(corrCount);
`else
        return 8'd0;
`endif
    endfunction

    // Drive a one-cycle rx_valid pulse and advance to the cycle where OUTPUT is visible.
    task automatic presentWord(input logic [6:0] w);
        @(negedge clk);
        rx       = w;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, out_valid, data_out, err_corrected, err_pos, err_count} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%0b ov=%0b d=%0h ec=%0b pos=%0d cnt=%0d required all zero",
                     busy, out_valid, data_out, err_corrected, err_pos, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%0b ov=%0b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [6:0] words [5] = '{7'h2D, 7'h3D, 7'h4A, 7'h00, 7'h4B};
        logic [3:0] datas [5] = '{4'd5, 4'd5, 4'd8, 4'd0, 4'd8};
        logic [2:0] poss  [5] = '{3'd0, 3'd5, 3'd1, 3'd0, 3'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            presentWord(words[i]);
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL vec%0d_valid: got ov=%0b busy=%0b required 1 1", i, out_valid, busy);
            end
            checks++;
            if (data_out !== datas[i] || err_pos !== poss[i] || err_corrected !== (poss[i] != 3'd0)) begin
                errors++;
                $display("[TB] FAIL vec%0d_result: got d=%0h pos=%0d ec=%0b required d=%0h pos=%0d ec=%0b",
                         i, data_out, err_pos, err_corrected, datas[i], poss[i], poss[i] != 3'd0);
            end
            @(negedge clk);
            modelHandshake(words[i]);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || err_count !== expErrCount()) begin
                errors++;
                $display("[TB] FAIL vec%0d_after: got ov=%0b busy=%0b cnt=%0d required 0 0 %0d",
                         i, out_valid, busy, err_count, expErrCount());
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = 7'($urandom_range(0, 127));
            presentWord(w);
            checks++;
            if (out_valid !== 1'b1 || data_out !== modelData(w) || err_pos !== modelSyndrome(w)
                || err_corrected !== (modelSyndrome(w) != 3'd0)) begin
                errors++;
                $display("[TB] FAIL rand_word_%0h: got ov=%0b d=%0h pos=%0d ec=%0b required 1 d=%0h pos=%0d",
                         w, out_valid, data_out, err_pos, err_corrected, modelData(w), modelSyndrome(w));
            end
            @(negedge clk);
            modelHandshake(w);
            checks++;
            if (err_count !== expErrCount() || data_out !== modelData(w)) begin
                errors++;
                $display("[TB] FAIL rand_after_%0h: got cnt=%0d d=%0h required cnt=%0d d=%0h",
                         w, err_count, data_out, expErrCount(), modelData(w));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        presentWord(7'h2D);
        for (int i = 0; i < 5; i++) begin
            rx       = (i % 2 == 0) ? 7'h7F : 7'h00;
            rx_valid = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || data_out !== 4'd5 || err_pos !== 3'd0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got ov=%0b busy=%0b d=%0h pos=%0d required 1 1 5 0",
                         i, out_valid, busy, data_out, err_pos);
            end
            @(negedge clk);
        end
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        modelHandshake(7'h2D);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 4'd5) begin
            errors++;
            $display("[TB] FAIL release_idle: got ov=%0b busy=%0b d=%0h required 0 0 5", out_valid, busy, data_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_queued_word: got busy=%0b ov=%0b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a;
        logic [6:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 7'($urandom_range(0, 127));
            b = 7'($urandom_range(0, 127));
            @(negedge clk);
            rx       = a;
            rx_valid = 1'b1;
            @(negedge clk);
            rx = b;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || data_out !== modelData(a) || err_pos !== modelSyndrome(a)) begin
                errors++;
                $display("[TB] FAIL b2b_first_%0h: got ov=%0b d=%0h pos=%0d required 1 d=%0h pos=%0d",
                         a, out_valid, data_out, err_pos, modelData(a), modelSyndrome(a));
            end
            @(negedge clk);
            modelHandshake(a);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_gap: got ov=%0b busy=%0b required 0 0", out_valid, busy);
            end
            @(negedge clk);
            rx_valid = 1'b0;
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_capture: got busy=%0b ov=%0b required 1 0", busy, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || data_out !== modelData(b) || err_pos !== modelSyndrome(b)) begin
                errors++;
                $display("[TB] FAIL b2b_second_%0h: got ov=%0b d=%0h pos=%0d required 1 d=%0h pos=%0d",
                         b, out_valid, data_out, err_pos, modelData(b), modelSyndrome(b));
            end
            @(negedge clk);
            modelHandshake(b);
            checks++;
            if (err_count !== expErrCount()) begin
                errors++;
                $display("[TB] FAIL b2b_count: got %0d required %0d", err_count, expErrCount());
            end
        end
    endtask

    task automatic test_reset_mid_decode();
        out_ready = 1'b1;
        presentWord(7'h3D);
        @(negedge clk);
        modelHandshake(7'h3D);
        @(negedge clk);
        rx       = 7'h3D;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_out !== 4'd5 || err_pos !== 3'd5) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: got busy=%0b d=%0h pos=%0d required 1 5 5", busy, data_out, err_pos);
        end
        #1 rst_n = 1'b0;
        corrCount = 0;
        #1;
        checks++;
        if ({busy, out_valid, data_out, err_corrected, err_pos, err_count} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%0b ov=%0b d=%0h ec=%0b pos=%0d cnt=%0d required all zero",
                     busy, out_valid, data_out, err_corrected, err_pos, err_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset%0d: got ov=%0b busy=%0b required 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_err_count();
        logic [6:0] w;
        logic [3:0] d;
        int pos;
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            d   = 4'($urandom_range(0, 15));
            pos = int'($urandom_range(1, 7));
            w   = modelEncode(d);
            w[pos-1] = ~w[pos-1];
            presentWord(w);
            checks++;
            if (data_out !== d || err_pos !== 3'(pos) || err_corrected !== 1'b1) begin
                errors++;
                $display("[TB] FAIL flip_word_%0h: got d=%0h pos=%0d ec=%0b required d=%0h pos=%0d ec=1",
                         w, data_out, err_pos, err_corrected, d, pos);
            end
            @(negedge clk);
            modelHandshake(w);
            checks++;
            if (err_count !== expErrCount()) begin
                errors++;
                $display("[TB] FAIL err_count_%0d: got %0d required %0d", i, err_count, expErrCount());
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx        = 7'd0;
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_decode();
        test_err_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
